// File: rtl/shift_add_mult_if.sv
// Operand/product handshake bundle for the sequential shift-add multiplier.
// The master side offers operands and accepts products; the slave side is the multiplier.
interface shift_add_mult_if;
   logic       in_valid;
   logic       in_ready;
   logic [3:0] a;
   logic [3:0] b;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] product;
   logic       busy;

   modport master (
      output in_valid, a, b, out_ready,
      input  in_ready, out_valid, product, busy
   );

   modport slave (
      input  in_valid, a, b, out_ready,
      output in_ready, out_valid, product, busy
   );
endinterface

// File: rtl/shift_add_mult.sv
// Sequential 4x4 unsigned multiplier: adds one shifter partial product per RUN cycle,
// selected by the multiplier bits, and hands the 8-bit product out through valid/ready.
module shifter (
   input  logic [3:0] a,
   input  logic [1:0] b,
   output logic [6:0] y
);
   assign y = {3'b000, a} << b;
endmodule

module shift_add_mult #(
   parameter bit SKIP_ZERO = 1'b1
) (
   input  logic           clk,
   input  logic           rst,
   shift_add_mult_if.slave bus
);
   typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

   state_t     state;
   state_t     state_nxt;
   logic [3:0] a_reg;
   logic [3:0] b_reg;
   logic [1:0] idx;
   logic [7:0] acc;
   logic [7:0] acc_nxt;
   logic [7:0] product_reg;
   logic [6:0] y;
   logic       accept;
   logic       last;

   shifter u_shifter (.a(a_reg), .b(idx), .y(y));

   assign accept  = bus.in_valid && (state == IDLE);
   assign acc_nxt = b_reg[idx] ? acc + {1'b0, y} : acc;
   // The final RUN cycle is idx 3, or earlier once no higher multiplier bit is set.
   assign last    = (idx == 2'd3) || (SKIP_ZERO && (((b_reg >> idx) >> 1) == 4'd0));

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // NOTE: every always_comb output gets a default first, otherwise missed branches infer latches.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (accept)        state_nxt = RUN;
         RUN:     if (last)          state_nxt = DONE;
         DONE:    if (bus.out_ready) state_nxt = IDLE;
         default:                    state_nxt = IDLE;
      endcase
   end

   always_comb begin
      bus.in_ready  = 1'b0;
      bus.out_valid = 1'b0;
      bus.busy      = 1'b1;
      case (state)
         IDLE: begin
            bus.in_ready = 1'b1;
            bus.busy     = 1'b0;
         end
         DONE:    bus.out_valid = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_reg       <= '0;
         b_reg       <= '0;
         idx         <= '0;
         acc         <= '0;
         product_reg <= '0;
      end else begin
         case (state)
            IDLE: if (accept) begin
               a_reg <= bus.a;
               b_reg <= bus.b;
               acc   <= '0;
               idx   <= '0;
            end
            RUN: begin
               acc <= acc_nxt;
               idx <= idx + 2'd1;
               // Product register only changes when a new result is ready, so it holds through IDLE.
               if (last) product_reg <= acc_nxt;
            end
            default: ;
         endcase
      end
   end

   assign bus.product = product_reg;
endmodule

// File: doc/shift_add_mult.md
Name: shift_add_mult

Overview:
Sequential 4x4 unsigned multiplier that sits directly downstream of the existing combinational shifter and consumes its output. The shifter computes y = a << b, with a 4-bit, b 2-bit and y 7-bit. This block instantiates one shifter and accumulates one partial product per cycle, selected by the multiplier bits, into an 8-bit product. Operands arrive and products leave through valid/ready handshakes.

Parameters:
SKIP_ZERO, 1, 1 = leave RUN early once all remaining multiplier bits are zero; 0 = always run exactly 4 RUN cycles.

Ports:
clk  input  1  single clock, rising edge
rst  input  1  asynchronous, active-high reset
in_valid  input  1  operands a/b valid
in_ready  output  1  block can accept operands
a  input  4  multiplicand, drives the shifter's a
b  input  4  multiplier
out_valid  output  1  product valid
out_ready  input  1  consumer accepts product
product  output  8  a*b, unsigned
busy  output  1  high in RUN or DONE

Behaviour:
- One clock (clk). Reset rst is asynchronous and active-high.
- Reset values: state=IDLE, in_ready=1, out_valid=0, product=0, busy=0, acc=0, idx=0, a_reg=0, b_reg=0.
- Reset asserted mid-operation: the operation is abandoned immediately; no product is ever presented for it.
- FSM has three states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready at an edge: latch a_reg=a, b_reg=b, clear acc=0, set idx=0, go to RUN.
- RUN:
  - in_ready=0. The shifter is driven with a=a_reg and b=idx[1:0].
  - Each edge: if b_reg[idx]=1, acc <= acc + {1'b0, y}; otherwise acc is unchanged. idx <= idx+1.
  - Exit to DONE on the edge that processes idx=3.
  - If SKIP_ZERO=1, also exit on the edge processing idx when b_reg[3:idx+1]==0, or when idx=3.
  - RUN always lasts at least one cycle, including when b=0.
- DONE:
  - out_valid=1. product=acc, held stable while out_ready=0.
  - On out_valid&&out_ready at an edge: go to IDLE, out_valid=0.
  - product keeps its last value after the transfer until the next DONE.
- Latency is measured from the accept edge N.
  - SKIP_ZERO=0: out_valid rises after edge N+4.
  - SKIP_ZERO=1: out_valid rises after edge N+k, where k = max(1, index of highest set bit of b + 1).
- Throughput: no bypass. in_ready=0 in RUN and DONE. The next accept can occur at the earliest one cycle after the output transfer edge, i.e. in IDLE.
- Input changes on a/b/in_valid outside IDLE are ignored.
- out_ready may be held high continuously; the transfer then occurs on the first DONE cycle.
- Arithmetic:
  - acc is 8 bits. The shifter's 7-bit y is zero-extended.
  - Maximum result 15*15=225 fits in 8 bits, so overflow is impossible and no wrap handling is required.
- busy = (state != IDLE).

Test Plan:
- SKIP_ZERO=0, a=15, b=15, out_ready=1 → out_valid exactly 4 cycles after the accept edge, product=225 (8'hE1), then in_ready=1 the following cycle.
- SKIP_ZERO=1, a=7, b=0 → out_valid after 1 cycle, product=0. Same a with b=1 → 1 cycle, product=7. b=4'b0100 → 3 cycles, product=28.
- Backpressure: a=9, b=6, out_ready=0 for 5 cycles after out_valid → product stays 54 and in_ready stays 0 throughout. A new in_valid (a=3, b=3) offered during DONE is not accepted. Raising out_ready completes the transfer, after which a=3, b=3 is accepted and yields 9.
- Reset mid-RUN: accept a=12, b=13, assert rst asynchronously after 2 cycles → out_valid=0, product=0 and in_ready=1 immediately. No stale product ever appears. The next operation a=2, b=3 returns 6.
- Exhaustive check:
  - Cover all 256 {a,b} pairs back-to-back with random out_ready stalls, for both parameter values.
  - A scoreboard compares each handshaken product against a*b.
  - Assert the product is stable while out_valid&&!out_ready.
  - Count exactly one output per accepted input.
